hazard_ctrl_p: RTL

- Parametrised successor to the fixed 2-port pipeline hazard unit. Drives the five-stage 48-bit pipeline (F/D/E/M/W).
- Adds N read ports, configurable address width and configurable load-use latency.
- Adds a forwarding-disable mode and memory-ready back-pressure that freezes the whole pipeline.
- Adds saturating stall/flush performance counters.
- Sits between the pipeline registers and the core datapath; combinational controls are registered internally only where stated.

---
 rtl/hazard_ctrl_p.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl_p.sv
// Parametrised hazard unit for the five-stage F/D/E/M/W pipeline.
// Produces forwarding selects, RAW/load-use stalls, memory back-pressure and perf counters.
module hazard_ctrl_p #(
  parameter int unsigned AW       = 5,
  parameter int unsigned NRP      = 2,
  parameter int unsigned LOAD_LAT = 1,
  parameter bit          FWD_EN   = 1'b1,
  parameter int unsigned CW       = 16
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [NRP*AW-1:0] RAD,
  input  logic [NRP*AW-1:0] RAE,
  input  logic [AW-1:0]     WA3E,
  input  logic [AW-1:0]     WA3M,
  input  logic [AW-1:0]     WA3W,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemToRegE,
  input  logic              BranchTakenE,
  input  logic              PCSrcD,
  input  logic              PCSrcE,
  input  logic              PCSrcM,
  input  logic              PCSrcW,
  input  logic              MemReqM,
  input  logic              MemReadyM,
  input  logic              ClrCnt,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic [2*NRP-1:0]  ForwardE,
  output logic [CW-1:0]     StallCnt,
  output logic [CW-1:0]     FlushCnt,
  output logic              Busy
);

  typedef enum logic {StRun, StLdStall} state_e;

  localparam logic [CW-1:0] CntMax = '1;
  localparam logic [3:0]    LdInit = 4'(LOAD_LAT - 1);

  state_e         stateQ, stateD;
  logic [3:0]     ldCntQ, ldCntD;
  logic [NRP-1:0] hitE, hitM;
  logic           memWait, loadUse, rawStall, decStall, pcStall;

  for (genvar i = 0; i < NRP; i++) begin : gPort
    logic [AW-1:0] rad, rae;
    logic          fwdM, fwdW;
    assign rad     = RAD[i*AW +: AW];
    assign rae     = RAE[i*AW +: AW];
    assign hitE[i] = (rad == WA3E);
    assign hitM[i] = (rad == WA3M);
    assign fwdM    = RegWriteM && (rae == WA3M);
    assign fwdW    = RegWriteW && (rae == WA3W);
    // M-stage result is younger, so it wins over W.
    assign ForwardE[2*i +: 2] = (!FWD_EN || !Reset) ? 2'b00 :
                                fwdM                ? 2'b10 :
                                fwdW                ? 2'b01 : 2'b00;
  end

  assign memWait  = MemReqM && !MemReadyM;
  assign loadUse  = FWD_EN && MemToRegE && (|hitE);
  // Without forwarding only E and M producers stall; W writes through the regfile.
  assign rawStall = !FWD_EN && ((RegWriteE && (|hitE)) || (RegWriteM && (|hitM)));
  assign decStall = loadUse || rawStall || (stateQ == StLdStall);
  assign pcStall  = PCSrcD || PCSrcE || PCSrcM;
  assign Busy     = (stateQ != StRun);

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (Reset) begin
      if (memWait) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        FlushD = PCSrcD || PCSrcE || PCSrcM || PCSrcW || BranchTakenE;
        FlushE = BranchTakenE || decStall;
        StallD = !BranchTakenE && decStall;
        StallF = !BranchTakenE && (decStall || pcStall);
      end
    end
  end

  always_comb begin
    stateD = stateQ;
    ldCntD = ldCntQ;
    if (!memWait) begin
      unique case (stateQ)
        StRun: begin
          if (loadUse && !BranchTakenE && (LOAD_LAT > 1)) begin
            stateD = StLdStall;
            ldCntD = LdInit;
          end
        end
        StLdStall: begin
          if (BranchTakenE || (ldCntQ == 4'd1)) begin
            stateD = StRun;
            ldCntD = 4'd0;
          end else begin
            ldCntD = ldCntQ - 4'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      stateQ <= StRun;
      ldCntQ <= 4'd0;
    end else begin
      stateQ <= stateD;
      ldCntQ <= ldCntD;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else if (ClrCnt) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallF && (StallCnt != CntMax)) StallCnt <= StallCnt + CW'(1);
      if ((FlushD || FlushE) && (FlushCnt != CntMax)) FlushCnt <= FlushCnt + CW'(1);
    end
  end

endmodule
